vga_pic_gen: RTL and testbench
==============================

# vga_pic_gen

Test-picture source that sits directly upstream of the VGA timing driver. It takes the driver's registered active-area pixel address and returns the 16-bit RGB565 word the driver displays. The picture is eight vertical colour bars with a square sprite over them. The sprite moves once per frame and bounces off the screen edges, so a bring-up board shows live motion without a frame buffer.

## Interface
Parameters:
- H_ACT, 640, active pixels per line
- V_ACT, 480, active lines per frame
- BOX, 32, sprite edge length in pixels
- STEP, 2, sprite displacement per frame in pixels, per axis (1..BOX)

Ports:
- clk  in  1  pixel clock; connect to the driver's vga_clk
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- addr_h  in  12  column address from driver: 1..H_ACT when active, 0 otherwise
- addr_v  in  12  line address from driver: 1..V_ACT when active, 0 otherwise
- v_sync  in  1  driver vertical sync; rising edge marks frame boundary
- move_en  in  1  1 = sprite advances at each frame boundary
- mode  in  2  picture select: 0 bars+sprite, 1 bars only, 2 sprite on black, 3 black
- rgb_data  out  16  RGB565 pixel to driver ({r5,g6,b5})
- frame_cnt  out  8  frame-boundary counter

## Operation
Frame boundary:
- Asserted when v_sync = 1 and v_sync_d = 0; v_sync_d is the registered copy.
- It is a one-cycle pulse, fe.

Mode:
- mode is sampled only on fe into mode_q, so a change never tears mid-frame.
- mode_q resets to 0.

Background bar:
- Bar index k = number of thresholds j·H_ACT/8 (j=1..7) that are less than addr_h. It is built from a comparator chain; no divider.
- Colours for k=0..7: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.

Sprite hit:
- box_x ≤ addr_h < box_x+BOX and box_y ≤ addr_v < box_y+BOX.
- Sprite colour is the bitwise inverse of the bar colour under it, so it is always visible.

Output pixel:
- 0000 when addr_h = 0 or addr_v = 0 (blanking).
- Otherwise by mode_q:
  - 0: sprite-hit ? ~bar : bar
  - 1: bar
  - 2: sprite-hit ? FFFF : 0000
  - 3: 0000

Motion, per axis, applied only on fe with move_en = 1:
- Two-state FSM, INC/DEC. MAX_X = H_ACT−BOX+1 = 609; MAX_Y = V_ACT−BOX+1 = 449.
- INC: if pos+STEP ≥ MAX, then pos ← MAX and state ← DEC; else pos ← pos+STEP.
- DEC: if pos ≤ 1+STEP, then pos ← 1 and state ← INC; else pos ← pos−STEP.
- With move_en = 0, position and state hold.
- All arithmetic is unsigned, 12 bits wide. Position never leaves 1..MAX.

frame_cnt:
- Increments on every fe, regardless of move_en.
- Wraps 255 → 0.

## Timing
- Reset state:
  - rgb_data = 0, frame_cnt = 0, mode_q = 0, v_sync_d = 0.
  - box_x = box_y = 1; both FSMs in INC.
- rgb_data is registered: 1 clk latency from addr_h/addr_v.
  - The driver's registered capture adds 1 clk on top.
  - The board-level alignment accepts this 1-pixel shift.
- fe fires in the vertical back porch, so position and mode_q settle before the first active line.
- Position, state, mode_q and frame_cnt all update on the clk edge that samples fe.
- Same-cycle fe and mode change: the mode value present in the fe cycle is latched.
- rst_n low at any time returns every register to its reset value on the next clk edge. No partial frame state survives.

## Structure
- Shared package vga_pkg holds:
  - H_ACT/V_ACT defaults;
  - RGB565 colour constants;
  - the mode encoding;
  - the INC/DEC direction type.
- Sub-module vga_bounce_axis, instantiated twice (x and y), contains:
  - parameters MAX and STEP;
  - inputs clk, rst_n and advance (fe & move_en);
  - output pos[11:0];
  - the INC/DEC FSM and clamp logic.
- Top level holds:
  - edge detect;
  - mode latch;
  - bar comparator chain;
  - hit test;
  - output mux/register;
  - frame_cnt.

## Test plan
- Reset and blanking:
  - Stimulus: hold rst_n = 0, then release; drive addr_h = 0 with addr_v = 100.
  - Required: rgb_data = 0000 and frame_cnt = 0.
  - Then drive addr = (200,0). Required: 0000.
- Bars, mode 0, with no fe:
  - (40,200) → FFFF; (81,200) → FFE0; (321,200) → F81F; (640,200) → 0000.
  - Each value appears 1 clk after the address.
- Sprite at reset position (1,1):
  - (1,1) → 0000; (32,32) → 0000; (33,1) → FFFF; (1,33) → FFFF.
- Motion and bounce, move_en = 1, one v_sync rising edge per frame:
  - After 1 edge: box_x = 3, box_y = 3.
  - After 224 edges: box_y = 449. After 225: box_y = 447.
  - After 304 edges: box_x = 609. After 305: box_x = 607.
  - frame_cnt after 305 edges = 49 (305 mod 256).
- Hold and mode latch:
  - With move_en = 0, 3 edges leave the position unchanged while frame_cnt advances by 3.
  - Change mode 0 → 1 mid-frame: rgb_data keeps the sprite until the next fe, and shows bars only after it.
- Reset mid-motion:
  - Stimulus: pulse rst_n low for 1 clk with box_x = 301 in state DEC.
  - Required: box_x = 1, state INC, mode_q = 0; the next fe gives box_x = 3.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-picture generator: default geometry,
// RGB565 colours, picture-mode encoding and sprite direction type.
package vga_pkg;

    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        MODE_BARS_SPRITE = 2'd0,
        MODE_BARS        = 2'd1,
        MODE_SPRITE      = 2'd2,
        MODE_BLACK       = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    function automatic logic [15:0] bar_colour(input logic [2:0] k);
        case (k)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of sprite motion: position walks between 1 and MAX by STEP,
// clamping onto the end stop and reversing direction there.
module vga_bounce_axis
    import vga_pkg::*;
#(
    parameter int MAX  = 609,
    parameter int STEP = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [11:0] pos
);

    localparam logic [11:0] MAX_W  = 12'(MAX);
    localparam logic [11:0] STEP_W = 12'(STEP);
    localparam logic [11:0] LOW_W  = 12'(1 + STEP);

    dir_e        dir_q, dir_d;
    logic [11:0] pos_q, pos_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= DIR_INC;
            pos_q <= 12'd1;
        end else begin
            dir_q <= dir_d;
            pos_q <= pos_d;
        end
    end

    // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
    always_comb begin
        dir_d = dir_q;
        pos_d = pos_q;
        if (advance) begin
            case (dir_q)
                DIR_INC: begin
                    if (pos_q + STEP_W >= MAX_W) begin
                        pos_d = MAX_W;
                        dir_d = DIR_DEC;
                    end else begin
                        pos_d = pos_q + STEP_W;
                    end
                end
                DIR_DEC: begin
                    if (pos_q <= LOW_W) begin
                        pos_d = 12'd1;
                        dir_d = DIR_INC;
                    end else begin
                        pos_d = pos_q - STEP_W;
                    end
                end
            endcase
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/vga_pic_gen.sv
// Test-picture source: eight colour bars with a bouncing inverted-colour
// sprite, one registered RGB565 word per active pixel address.
module vga_pic_gen
    import vga_pkg::*;
#(
    parameter int H_ACT = H_ACT_DEF,
    parameter int V_ACT = V_ACT_DEF,
    parameter int BOX   = 32,
    parameter int STEP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] addr_h,
    input  logic [11:0] addr_v,
    input  logic        v_sync,
    input  logic        move_en,
    input  logic [1:0]  mode,
    output logic [15:0] rgb_data,
    output logic [7:0]  frame_cnt
);

    logic        v_sync_d_q;
    mode_e       mode_q;
    logic [7:0]  frame_cnt_q;
    logic [15:0] rgb_q, rgb_d;
    logic        fe;
    logic [11:0] box_x, box_y;
    logic [2:0]  bar_idx;
    logic [15:0] bar_rgb;
    logic        hit;

    assign fe = v_sync & ~v_sync_d_q;

    vga_bounce_axis #(.MAX(H_ACT - BOX + 1), .STEP(STEP)) u_axis_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (fe & move_en),
        .pos     (box_x)
    );

    vga_bounce_axis #(.MAX(V_ACT - BOX + 1), .STEP(STEP)) u_axis_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (fe & move_en),
        .pos     (box_y)
    );

    // Bar index counts how many of the seven bar boundaries lie left of the pixel.
    always_comb begin
        bar_idx = 3'd0;
        for (int j = 1; j < 8; j++) begin
            if (12'(j * H_ACT / 8) < addr_h) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
    end

    assign bar_rgb = bar_colour(bar_idx);

    assign hit = (addr_h >= box_x) && (addr_h < box_x + 12'(BOX)) &&
                 (addr_v >= box_y) && (addr_v < box_y + 12'(BOX));

    always_comb begin
        rgb_d = RGB_BLACK;
        if (addr_h != 12'd0 && addr_v != 12'd0) begin
            case (mode_q)
                MODE_BARS_SPRITE: rgb_d = hit ? ~bar_rgb : bar_rgb;
                MODE_BARS:        rgb_d = bar_rgb;
                MODE_SPRITE:      rgb_d = hit ? RGB_WHITE : RGB_BLACK;
                MODE_BLACK:       rgb_d = RGB_BLACK;
            endcase
        end
    end

    // Mode is only taken at the frame boundary so a change never tears the picture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_sync_d_q  <= 1'b0;
            mode_q      <= MODE_BARS_SPRITE;
            frame_cnt_q <= 8'd0;
            rgb_q       <= RGB_BLACK;
        end else begin
            v_sync_d_q <= v_sync;
            rgb_q      <= rgb_d;
            if (fe) begin
                mode_q      <= mode_e'(mode);
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign rgb_data  = rgb_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pic_gen.sv
// Self-checking bench for vga_pic_gen: directed and randomized pixel probes
// compared against an arithmetic model of the picture and sprite motion.
module tb_vga_pic_gen;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int BOX   = 32;
    localparam int STEP  = 2;
    localparam int MAX_X = H_ACT - BOX + 1;
    localparam int MAX_Y = V_ACT - BOX + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr_h, addr_v;
    logic        v_sync, move_en;
    logic [1:0]  mode;
    logic [15:0] rgb_data;
    logic [7:0]  frame_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: sprite corner, direction (+1/-1), latched mode, frame count.
    int mx, my, mdx, mdy, mmode, mcnt;
    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    vga_pic_gen #(.H_ACT(H_ACT), .V_ACT(V_ACT), .BOX(BOX), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_h    (addr_h),
        .addr_v    (addr_v),
        .v_sync    (v_sync),
        .move_en   (move_en),
        .mode      (mode),
        .rgb_data  (rgb_data),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 1; my = 1; mdx = 1; mdy = 1; mmode = 0; mcnt = 0;
    endtask

    task automatic step_axis(inout int p, inout int d, input int lim);
        if (d > 0) begin
            p = p + STEP;
            if (p >= lim) begin p = lim; d = -1; end
        end else begin
            p = p - STEP;
            if (p <= 1) begin p = 1; d = 1; end
        end
    endtask

    function automatic logic [15:0] exp_pix(input int h, input int v);
        logic [15:0] bar;
        bit          in_box;
        if (h == 0 || v == 0) return 16'h0000;
        bar    = bar_tab[(h - 1) * 8 / H_ACT];
        in_box = (h >= mx) && (h < mx + BOX) && (v >= my) && (v < my + BOX);
        case (mmode)
            0:       return in_box ? ~bar : bar;
            1:       return bar;
            2:       return in_box ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    // One v_sync pulse; mode and move_en change in the same cycle as the rising edge.
    task automatic frame_edge(input int m, input bit en);
        @(negedge clk);
        mode    = 2'(m);
        move_en = en;
        v_sync  = 1'b1;
        @(negedge clk);
        v_sync = 1'b0;
        mcnt   = (mcnt + 1) % 256;
        mmode  = m;
        if (en) begin
            step_axis(mx, mdx, MAX_X);
            step_axis(my, mdy, MAX_Y);
        end
    endtask

    task automatic probe(input int h, input int v, input string tag);
        @(negedge clk);
        addr_h = 12'(h);
        addr_v = 12'(v);
        @(posedge clk);
        #1;
        check(tag, {16'h0, rgb_data}, {16'h0, exp_pix(h, v)});
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"}, {20'h0, dut.u_axis_x.pos}, mx);
        check({tag, "_y"}, {20'h0, dut.u_axis_y.pos}, my);
    endtask

    initial begin
        int guard;
        int c0;
        rst_n = 1'b0; addr_h = '0; addr_v = '0;
        v_sync = 1'b0; move_en = 1'b0; mode = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and blanking
        check("rst_rgb", {16'h0, rgb_data}, 32'h0);
        check("rst_cnt", {24'h0, frame_cnt}, 32'h0);
        check_pos("rst_pos");
        probe(0, 100, "blank_h0");
        probe(200, 0, "blank_v0");

        // Bars in mode 0, including one-clock latency
        probe(40, 200, "bar_40");
        @(negedge clk);
        addr_h = 12'd81;
        #1;
        check("lat_hold", {16'h0, rgb_data}, 32'hFFFF);
        @(posedge clk);
        #1;
        check("lat_new", {16'h0, rgb_data}, 32'hFFE0);
        probe(321, 200, "bar_321");
        probe(640, 200, "bar_640");

        // Sprite at reset position
        probe(1, 1, "spr_11");
        probe(32, 32, "spr_3232");
        probe(33, 1, "spr_331");
        probe(1, 33, "spr_133");

        repeat (12) probe($urandom_range(H_ACT, 0), $urandom_range(V_ACT, 0), "rnd_m0");

        // Motion and bounce
        frame_edge(0, 1'b1);
        check("edge1_x", {20'h0, dut.u_axis_x.pos}, 32'd3);
        check("edge1_y", {20'h0, dut.u_axis_y.pos}, 32'd3);
        for (int n = 2; n <= 305; n++) begin
            frame_edge(0, 1'b1);
            if (n == 224) check("bounce_y_top", {20'h0, dut.u_axis_y.pos}, 32'd449);
            if (n == 225) check("bounce_y_back", {20'h0, dut.u_axis_y.pos}, 32'd447);
            if (n == 304) check("bounce_x_top", {20'h0, dut.u_axis_x.pos}, 32'd609);
            if (n == 305) check("bounce_x_back", {20'h0, dut.u_axis_x.pos}, 32'd607);
            if (n % 32 == 0) check_pos("walk");
        end
        check("cnt_305", {24'h0, frame_cnt}, 32'd49);
        check_pos("after305");

        // Sprite edges in mode 2
        frame_edge(2, 1'b0);
        probe(mx, my, "m2_corner");
        probe(mx + BOX - 1, my + BOX - 1, "m2_far");
        probe(mx - 1, my, "m2_left");
        probe(mx + BOX, my, "m2_right");
        probe(mx, my + BOX, "m2_below");

        // Hold with move_en = 0
        c0 = mcnt;
        repeat (3) frame_edge(2, 1'b0);
        check("hold_x", {20'h0, dut.u_axis_x.pos}, 32'd607);
        check_pos("hold");
        check("hold_cnt", {24'h0, frame_cnt}, 32'((c0 + 3) % 256));

        // Mode latch: change mid-frame, visible only after the next boundary
        frame_edge(0, 1'b0);
        @(negedge clk);
        mode = 2'd1;
        probe(mx, my, "latch_pre");
        probe(mx + 5, my + 5, "latch_pre2");
        frame_edge(1, 1'b0);
        probe(mx, my, "latch_post");

        // Walk to x = 301 going down, then reset for one clock
        guard = 0;
        while (!(mx == 301 && mdx < 0) && guard < 1000) begin
            frame_edge(1, 1'b1);
            guard++;
        end
        check("pre_rst_x", {20'h0, dut.u_axis_x.pos}, 32'd301);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_pos("midrst");
        check("midrst_cnt", {24'h0, frame_cnt}, 32'h0);
        check("midrst_rgb", {16'h0, rgb_data}, 32'h0);
        probe(1, 1, "midrst_mode");
        frame_edge(0, 1'b1);
        check("midrst_next_x", {20'h0, dut.u_axis_x.pos}, 32'd3);

        // Randomized frames: mode, move_en and probes including sprite interior
        repeat (40) begin
            frame_edge($urandom_range(3, 0), 1'($urandom_range(1, 0)));
            check_pos("rnd");
            check("rnd_cnt", {24'h0, frame_cnt}, 32'(mcnt));
            probe(mx + $urandom_range(BOX - 1, 0), my + $urandom_range(BOX - 1, 0), "rnd_in");
            probe($urandom_range(H_ACT, 0), $urandom_range(V_ACT, 0), "rnd_any");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
